// File: rtl/diag_event_arbiter.sv
// diag_event_arbiter
//   Shares one event path into the diagnosis LUT between NUM_SRC monitors.
//   The monitors emit 1-cycle pulses and cannot be stalled, so each source has
//   a 1-entry holding slot. A round-robin arbiter drains the slots into one
//   registered valid/ready output. Events that hit a still-full slot are
//   dropped and counted in a saturating counter with a sticky overflow flag.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   diag_sys_enabled  0 = flush slots and output (drop_cnt/overflow hold)
//   ev_valid_flat     per-source event pulse
//   ev_id_flat        per-source id, source k at [k*ID_WIDTH +: ID_WIDTH]
//   ev_time_flat      per-source timestamp, same packing
//   out_valid/ready   output handshake
//   out_id/time/src   granted event and its source index
//   clr_drop          clears drop_cnt and overflow
//   drop_cnt          saturating count of dropped events
//   overflow          sticky, set on any drop

`ifndef DIAGNOSIS_EV_ID_WIDTH
`define DIAGNOSIS_EV_ID_WIDTH 8
`endif
`ifndef DIAGNOSIS_TIMESTAMP_WIDTH
`define DIAGNOSIS_TIMESTAMP_WIDTH 32
`endif

module diag_event_arbiter #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned ID_WIDTH       = `DIAGNOSIS_EV_ID_WIDTH,
    parameter int unsigned TIME_WIDTH     = `DIAGNOSIS_TIMESTAMP_WIDTH,
    parameter int unsigned DROP_CNT_WIDTH = 16,
    parameter int unsigned SRC_IDX_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           diag_sys_enabled,
    input  logic [NUM_SRC-1:0]             ev_valid_flat,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    ev_id_flat,
    input  logic [NUM_SRC*TIME_WIDTH-1:0]  ev_time_flat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic [TIME_WIDTH-1:0]          out_time,
    output logic [SRC_IDX_WIDTH-1:0]       out_src,
    input  logic                           clr_drop,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt,
    output logic                           overflow
);

    localparam int unsigned PC_WIDTH  = $clog2(NUM_SRC + 1);
    localparam int unsigned SUM_WIDTH =
        ((DROP_CNT_WIDTH > PC_WIDTH) ? DROP_CNT_WIDTH : PC_WIDTH) + 1;
    localparam logic [SUM_WIDTH-1:0]     CNT_MAX   = SUM_WIDTH'({DROP_CNT_WIDTH{1'b1}});
    localparam logic [SRC_IDX_WIDTH-1:0] LAST_SRC  = SRC_IDX_WIDTH'(NUM_SRC - 1);
    localparam logic [SRC_IDX_WIDTH:0]   NUM_SRC_W = (SRC_IDX_WIDTH + 1)'(NUM_SRC);

    logic [NUM_SRC-1:0]       slot_full;
    logic [ID_WIDTH-1:0]      slot_id   [NUM_SRC];
    logic [TIME_WIDTH-1:0]    slot_time [NUM_SRC];
    logic [SRC_IDX_WIDTH-1:0] rr_ptr;

    logic                     can_take;
    logic                     grant_valid;
    logic [SRC_IDX_WIDTH-1:0] grant_idx;
    logic [NUM_SRC-1:0]       granted;
    logic [NUM_SRC-1:0]       load;
    logic [NUM_SRC-1:0]       drop;
    logic [PC_WIDTH-1:0]      drop_pop;
    logic [SUM_WIDTH-1:0]     drop_sum;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_nxt;

    // Round-robin scan starting at rr_ptr; the first full slot wins.
    always_comb begin
        logic [SRC_IDX_WIDTH:0] pos;
        can_take    = !out_valid || out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pos = {1'b0, rr_ptr} + (SRC_IDX_WIDTH + 1)'(i);
            if (pos >= NUM_SRC_W) begin
                pos = pos - NUM_SRC_W;
            end
            if (can_take && !grant_valid && slot_full[pos[SRC_IDX_WIDTH-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = pos[SRC_IDX_WIDTH-1:0];
            end
        end
    end

    // Slot load (with bypass on grant), drop detection and drop counter update.
    always_comb begin
        granted  = '0;
        load     = '0;
        drop     = '0;
        drop_pop = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            granted[k] = grant_valid && (grant_idx == SRC_IDX_WIDTH'(k));
            load[k]    = ev_valid_flat[k] && (!slot_full[k] || granted[k]);
            drop[k]    = ev_valid_flat[k] && slot_full[k] && !granted[k];
            drop_pop   = drop_pop + PC_WIDTH'(drop[k]);
        end
        drop_sum     = (clr_drop ? '0 : SUM_WIDTH'(drop_cnt)) + SUM_WIDTH'(drop_pop);
        drop_cnt_nxt = (drop_sum > CNT_MAX) ? DROP_CNT_WIDTH'(CNT_MAX)
                                            : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_time  <= '0;
            out_src   <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else if (!diag_sys_enabled) begin
            // Flush like reset, but keep the drop statistics.
            slot_full <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_time  <= '0;
            out_src   <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (load[k]) begin
                    slot_full[k] <= 1'b1;
                    slot_id[k]   <= ev_id_flat[k*ID_WIDTH +: ID_WIDTH];
                    slot_time[k] <= ev_time_flat[k*TIME_WIDTH +: TIME_WIDTH];
                end else if (granted[k]) begin
                    slot_full[k] <= 1'b0;
                end
            end

            if (grant_valid) begin
                out_valid <= 1'b1;
                out_id    <= slot_id[grant_idx];
                out_time  <= slot_time[grant_idx];
                out_src   <= grant_idx;
                rr_ptr    <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            drop_cnt <= drop_cnt_nxt;
            if (clr_drop) begin
                overflow <= |drop;
            end else if (|drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_diag_event_arbiter.sv
// tb_diag_event_arbiter
//   Scoreboard bench for diag_event_arbiter. Stimulus pushes the expected
//   output events into exp_q; a negedge monitor pops and compares on every
//   accepted output. A second instance with a 2-bit drop counter exercises
//   saturation and clear.

module tb_diag_event_arbiter;

    localparam int IW = 8;
    localparam int TW = 16;
    localparam int SW = 2;
    localparam int N  = 3;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] t;
        logic [SW-1:0] src;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    ev_valid;
    logic [N*IW-1:0] ev_id;
    logic [N*TW-1:0] ev_time;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_id;
    logic [TW-1:0]   out_time;
    logic [SW-1:0]   out_src;
    logic            clr_drop;
    logic [15:0]     drop_cnt;
    logic            overflow;

    logic [N-1:0]    s_ev_valid;
    logic            s_out_valid;
    logic            s_out_ready;
    logic [IW-1:0]   s_out_id;
    logic [TW-1:0]   s_out_time;
    logic [SW-1:0]   s_out_src;
    logic            s_clr_drop;
    logic [1:0]      s_drop_cnt;
    logic            s_overflow;

    ev_t         exp_q[$];
    int unsigned acc_cyc[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    diag_event_arbiter #(
        .NUM_SRC(N), .ID_WIDTH(IW), .TIME_WIDTH(TW), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .diag_sys_enabled(en),
        .ev_valid_flat(ev_valid), .ev_id_flat(ev_id), .ev_time_flat(ev_time),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_time(out_time), .out_src(out_src), .clr_drop(clr_drop),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    diag_event_arbiter #(
        .NUM_SRC(N), .ID_WIDTH(IW), .TIME_WIDTH(TW), .DROP_CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .diag_sys_enabled(en),
        .ev_valid_flat(s_ev_valid), .ev_id_flat(ev_id), .ev_time_flat(ev_time),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_id(s_out_id),
        .out_time(s_out_time), .out_src(s_out_src), .clr_drop(s_clr_drop),
        .drop_cnt(s_drop_cnt), .overflow(s_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted event and check stability while stalled.
    logic prev_stall = 1'b0;
    ev_t  prev_ev;
    always @(negedge clk) begin
        ev_t cur;
        ev_t e;
        cur = '{id: out_id, t: out_time, src: out_src};
        if (prev_stall && out_valid) begin
            chk("stall_hold", 64'(cur), 64'(prev_ev));
        end
        if (out_valid && out_ready) begin
            acc_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    failures++;
                    $display("FAIL out_event actual=%0h required=%0h", cur, e);
                end
            end
        end
        prev_stall = out_valid && !out_ready && en && !rst;
        prev_ev    = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input int k, input logic [IW-1:0] id, input logic [TW-1:0] t,
                          input bit expect_out);
        ev_valid[k]           = 1'b1;
        ev_id[k*IW +: IW]     = id;
        ev_time[k*TW +: TW]   = t;
        if (expect_out) exp_q.push_back('{id: id, t: t, src: SW'(k)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_consec(input string name, input int n);
        int unsigned m;
        m = acc_cyc.size();
        if (m < n) chk(name, 64'(m), 64'(n));
        else       chk(name, 64'(acc_cyc[m-1] - acc_cyc[m-n]), 64'(n - 1));
    endtask

    task automatic pulse_all3(input logic [IW-1:0] id0, input logic [TW-1:0] t0);
        for (int k = 0; k < N; k++) set_ev(k, id0 + IW'(k), t0 + TW'(k), 1'b1);
        tick();
        ev_valid = '0;
        wait_drain();
        check_consec("rr_consecutive", 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        rst = 1'b1; en = 1'b1; ev_valid = '0; ev_id = '0; ev_time = '0;
        out_ready = 1'b1; clr_drop = 1'b0;
        s_ev_valid = '0; s_out_ready = 1'b0; s_clr_drop = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_out_time", 64'(out_time), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        tick();

        // Saturation and clear on the 2-bit counter instance (output stalled).
        s_ev_valid = 3'b111; tick();                    // all slots load
        s_ev_valid = 3'b111; tick();                    // src0 granted+refilled, 2 drops
        @(negedge clk);
        chk("sat_cnt_2", 64'(s_drop_cnt), 64'd2);
        chk("sat_out_src", 64'(s_out_src), 64'd0);
        s_ev_valid = 3'b111; tick();                    // 3 drops -> saturate
        @(negedge clk);
        chk("sat_cnt_3", 64'(s_drop_cnt), 64'd3);
        chk("sat_overflow", 64'(s_overflow), 64'd1);
        s_ev_valid = 3'b110; s_clr_drop = 1'b1; tick(); // clear with 2 drops
        @(negedge clk);
        chk("clr_with_drops_cnt", 64'(s_drop_cnt), 64'd2);
        chk("clr_with_drops_ovf", 64'(s_overflow), 64'd1);
        s_ev_valid = 3'b000; tick();                    // clear with no drops
        s_clr_drop = 1'b0;
        @(negedge clk);
        chk("clr_cnt", 64'(s_drop_cnt), 64'd0);
        chk("clr_ovf", 64'(s_overflow), 64'd0);

        // Round-robin from rr_ptr=0, twice to show rr_ptr wraps back to 0.
        pulse_all3(8'h20, 16'd10);
        pulse_all3(8'h30, 16'd20);

        // Single event latency.
        tick();
        c0 = cyc;
        set_ev(1, 8'd5, 16'd100, 1'b1);
        tick();
        ev_valid = '0;
        @(negedge clk);
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t1_one_cycle", 64'(out_valid), 64'd0);
        wait_drain();
        chk("t1_latency", 64'(acc_cyc[$]), 64'(c0 + 2));
        chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);

        // Backpressure and drop on source 2.
        out_ready = 1'b0;
        set_ev(2, 8'd1, 16'd200, 1'b1); tick();
        set_ev(2, 8'd2, 16'd201, 1'b1); tick();
        set_ev(2, 8'd3, 16'd202, 1'b0); tick();
        ev_valid = '0;
        @(negedge clk);
        chk("bp_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_out_id", 64'(out_id), 64'd1);
        tick();
        out_ready = 1'b1;
        wait_drain();
        chk("bp_order", 64'(acc_cyc[$] - acc_cyc[acc_cyc.size()-2]), 64'd1);

        // Streaming on source 0.
        for (int i = 0; i < 10; i++) begin
            set_ev(0, 8'h40 + IW'(i), 16'd300 + TW'(i), 1'b1);
            tick();
        end
        ev_valid = '0;
        wait_drain();
        check_consec("stream_consecutive", 10);
        chk("stream_drop_cnt", 64'(drop_cnt), 64'd1);

        // Disable and reset while stalled with two full slots and drop_cnt=4.
        clr_drop = 1'b1; tick(); clr_drop = 1'b0;
        @(negedge clk);
        chk("clr_main_cnt", 64'(drop_cnt), 64'd0);
        chk("clr_main_ovf", 64'(overflow), 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ev(0, 8'h50, 16'd400, 1'b0);
            set_ev(1, 8'h51, 16'd401, 1'b0);
            tick();
        end
        ev_valid = '0;
        set_ev(0, 8'h52, 16'd402, 1'b0); tick();
        ev_valid = '0;
        @(negedge clk);
        chk("pre_dis_valid", 64'(out_valid), 64'd1);
        chk("pre_dis_cnt", 64'(drop_cnt), 64'd4);
        en = 1'b0;
        ev_valid = 3'b111;
        tick();
        ev_valid = '0;
        en = 1'b1;
        @(negedge clk);
        chk("dis_valid", 64'(out_valid), 64'd0);
        chk("dis_cnt", 64'(drop_cnt), 64'd4);
        chk("dis_ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("dis_slots_empty", 64'(acc_cyc.size()), 64'd19);
        pulse_all3(8'h60, 16'd500);                     // rr_ptr back at 0
        set_ev(1, 8'h70, 16'd600, 1'b1); tick();        // leaves rr_ptr=2
        ev_valid = '0;
        wait_drain();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst2_cnt", 64'(drop_cnt), 64'd0);
        chk("rst2_ovf", 64'(overflow), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        pulse_all3(8'h80, 16'd700);                     // rr_ptr reset to 0

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
